// File: rtl/disp_rd_sched.sv
// Frame-buffer read scheduler: issues fixed-length burst reads for one frame at a time
// and forwards the returned words to the display FIFO, tagged with SOF/EOF.
module disp_rd_sched #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_WORDS = 128000,
  parameter int unsigned MAX_OUTST   = 2,
  parameter int unsigned DSIZE       = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              disp_fifo_rdy,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              mem_rd_vld,
  input  logic [31:0]       mem_rd_data,
  output logic              burst_vld,
  output logic [DSIZE-1:0]  burst_rd_data,
  output logic              frame_done,
  output logic              busy,
  output logic              proto_err
);

  localparam int unsigned CNT_W    = $clog2(FRAME_WORDS);
  localparam int unsigned BEAT_W   = $clog2(BURST_LEN);
  localparam int unsigned N_BURSTS = FRAME_WORDS / BURST_LEN;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic                req_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   req_addr;
  logic [CNT_W-1:0]    burst_idx;
  logic [CNT_W-1:0]    word_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [1:0]          outst;
  logic                done_seen;
  logic                issue, accept, last_beat, last_word, last_burst;

  assign issue      = rd_req & rd_gnt;
  assign accept     = mem_rd_vld & (outst != 2'd0);
  assign last_beat  = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign last_word  = (word_cnt == CNT_W'(FRAME_WORDS - 1));
  assign last_burst = (burst_idx == CNT_W'(N_BURSTS - 1));
  assign busy       = (state != S_IDLE);

  // Burst offset is idx*BURST_LEN; the address wraps modulo 2^ADDR_W.
  assign req_addr = base_q + ADDR_W'({burst_idx, {BEAT_W{1'b0}}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = rd_req;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (disp_fifo_rdy && (outst < 2'(MAX_OUTST))) begin
          state_nxt = S_REQ;
          req_nxt   = 1'b1;
        end
      end
      S_REQ: begin
        if (rd_gnt) begin
          req_nxt   = 1'b0;
          state_nxt = last_burst ? S_DRAIN : S_WAIT;
        end
      end
      S_DRAIN: begin
        if ((outst == 2'd0) && (done_seen || frame_done))
          state_nxt = enable ? S_LOAD : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req        <= 1'b0;
      rd_addr       <= '0;
      base_q        <= '0;
      burst_idx     <= '0;
      word_cnt      <= '0;
      beat_cnt      <= '0;
      outst         <= '0;
      done_seen     <= 1'b0;
      burst_vld     <= 1'b0;
      burst_rd_data <= '0;
      frame_done    <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      rd_req <= req_nxt;
      if (state == S_WAIT && state_nxt == S_REQ) rd_addr <= req_addr;

      if (state == S_LOAD) begin
        base_q    <= frame_base;
        burst_idx <= '0;
      end else if (issue) begin
        burst_idx <= burst_idx + CNT_W'(1);
      end

      // A grant and a burst completion in the same cycle cancel out.
      case ({issue, accept & last_beat})
        2'b10:   outst <= outst + 2'd1;
        2'b01:   outst <= outst - 2'd1;
        default: outst <= outst;
      endcase

      if (accept) begin
        beat_cnt      <= beat_cnt + BEAT_W'(1);
        word_cnt      <= last_word ? '0 : word_cnt + CNT_W'(1);
        burst_rd_data <= DSIZE'({last_word, (word_cnt == '0), mem_rd_data});
      end
      burst_vld  <= accept;
      frame_done <= accept & last_word;

      if (mem_rd_vld && (outst == 2'd0)) proto_err <= 1'b1;

      if (state == S_LOAD)  done_seen <= 1'b0;
      else if (frame_done)  done_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_disp_rd_sched.sv
// Randomised bench for disp_rd_sched: a transaction-level memory/grant model drives the DUT
// and a frame/word scoreboard predicts every request address and every pushed word.
module tb_disp_rd_sched;

  localparam int unsigned AW   = 24;
  localparam int unsigned BL   = 16;
  localparam int unsigned FW   = 320;
  localparam int unsigned MAXO = 2;
  localparam int unsigned DS   = 36;
  localparam int unsigned NB   = FW / BL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [AW-1:0] frame_base;
  logic          disp_fifo_rdy;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          mem_rd_vld;
  logic [31:0]   mem_rd_data;
  logic          burst_vld;
  logic [DS-1:0] burst_rd_data;
  logic          frame_done;
  logic          busy;
  logic          proto_err;

  always #5 clk = ~clk;

  disp_rd_sched #(
    .ADDR_W(AW), .BURST_LEN(BL), .FRAME_WORDS(FW), .MAX_OUTST(MAXO), .DSIZE(DS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_base(frame_base),
    .disp_fifo_rdy(disp_fifo_rdy), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .mem_rd_vld(mem_rd_vld), .mem_rd_data(mem_rd_data), .burst_vld(burst_vld),
    .burst_rd_data(burst_rd_data), .frame_done(frame_done), .busy(busy), .proto_err(proto_err)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // stimulus knobs
  int unsigned gnt_pct, mem_pct, lat;
  bit          inject_err;

  // reference model state
  int unsigned   outst, req_cnt, frame_reqs, out_idx, frames, cyc, beat;
  logic [AW-1:0] exp_base;
  bit            perr_exp, saw_max;
  bit            p_req, p_gnt, p_mvld, p_legit, p_last;
  logic [AW-1:0] p_addr;
  logic [AW-1:0] mq_addr[$];
  int unsigned   mq_rdy[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fdat(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, a};
  endfunction

  task automatic model_reset();
    outst = 0; req_cnt = 0; frame_reqs = 0; out_idx = 0; beat = 0; perr_exp = 0;
    p_req = 0; p_gnt = 0; p_mvld = 0; p_legit = 0; p_last = 0; p_addr = '0;
    mq_addr.delete(); mq_rdy.delete();
  endtask

  task automatic chk_zero_outputs();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_burst_vld", burst_vld, 0);
    chk("rst_burst_data", burst_rd_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);
  endtask

  // One clock: observe the edge just passed, update the model, drive the next inputs.
  task automatic cycle();
    int unsigned   gate_outst;
    logic [AW-1:0] ea;
    @(negedge clk);
    cyc++;
    gate_outst = outst;

    if (p_req && p_gnt) begin
      chk("req_drop_after_gnt", rd_req, 0);
      outst++;
      frame_reqs++;
      req_cnt = (req_cnt + 1 == NB) ? 0 : req_cnt + 1;
      chk("outst_limit", outst <= MAXO, 1);
      if (outst == MAXO) saw_max = 1;
      mq_addr.push_back(p_addr);
      mq_rdy.push_back(cyc + lat);
    end

    if (p_mvld && p_legit) begin
      ea = exp_base + AW'(out_idx);
      chk("burst_vld", burst_vld, 1);
      chk("burst_data", burst_rd_data, {2'b00, out_idx == FW - 1, out_idx == 0, fdat(ea)});
      chk("frame_done", frame_done, out_idx == FW - 1);
      if (out_idx == FW - 1) begin
        chk("reqs_per_frame", frame_reqs, NB);
        frame_reqs = 0;
        out_idx = 0;
        frames++;
      end else begin
        out_idx++;
      end
      if (p_last) outst--;
    end else begin
      chk("burst_vld_quiet", burst_vld, 0);
      chk("frame_done_quiet", frame_done, 0);
      if (p_mvld) perr_exp = 1;
    end
    chk("proto_err", proto_err, perr_exp);

    if (rd_req) begin
      if (!p_req) begin
        chk("issue_gate", {disp_fifo_rdy, gate_outst < MAXO}, 2'b11);
        if (req_cnt == 0) exp_base = frame_base;
      end
      ea = exp_base + AW'(req_cnt * BL);
      chk("rd_addr", rd_addr, ea);
      chk("busy_while_req", busy, 1);
    end

    p_req  = rd_req;
    p_addr = rd_addr;
    rd_gnt = rd_req ? ($urandom_range(99) < gnt_pct) : ($urandom_range(7) == 0);
    p_gnt  = rd_gnt;

    mem_rd_vld = 1'b0;
    p_legit = 0;
    p_last  = 0;
    if (inject_err) begin
      mem_rd_vld  = 1'b1;
      mem_rd_data = $urandom;
      inject_err  = 0;
    end else if (mq_addr.size() != 0 && cyc >= mq_rdy[0] && $urandom_range(99) < mem_pct) begin
      ea = mq_addr[0] + AW'(beat);
      mem_rd_vld  = 1'b1;
      mem_rd_data = fdat(ea);
      p_legit = 1;
      beat++;
      if (beat == BL) begin
        beat = 0;
        p_last = 1;
        void'(mq_addr.pop_front());
        void'(mq_rdy.pop_front());
      end
    end
    p_mvld = mem_rd_vld;
  endtask

  task automatic run_frames(input int unsigned target, input int unsigned budget, input string tag);
    for (int unsigned i = 0; i < budget && frames < target; i++) cycle();
    chk(tag, frames >= target, 1);
  endtask

  task automatic wait_req(input int unsigned budget, input string tag);
    for (int unsigned i = 0; i < budget && !rd_req; i++) cycle();
    chk(tag, rd_req, 1);
  endtask

  task automatic wait_idx(input int unsigned n, input int unsigned budget, input string tag);
    for (int unsigned i = 0; i < budget && out_idx < n; i++) cycle();
    chk(tag, out_idx >= n, 1);
  endtask

  task automatic wait_idle(input int unsigned budget, input string tag);
    for (int unsigned i = 0; i < budget && busy; i++) cycle();
    chk(tag, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned idx0, tgt;
    rst_n = 1'b0; enable = 1'b0; frame_base = '0; disp_fifo_rdy = 1'b1;
    rd_gnt = 1'b0; mem_rd_vld = 1'b0; mem_rd_data = '0; inject_err = 0;
    gnt_pct = 100; mem_pct = 100; lat = 1; frames = 0; cyc = 0; saw_max = 0;
    exp_base = '0;
    model_reset();

    #12;
    chk_zero_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_busy", busy, 0);

    // first frame: first request held ungranted, then immediate grants, 1-cycle memory
    frame_base = 24'h001000;
    enable = 1'b1;
    gnt_pct = 0;
    wait_req(20, "s1_req_seen");
    chk("s1_first_addr", rd_addr, 24'h001000);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("s2_req_held", rd_req, 1);
      chk("s2_addr_held", rd_addr, 24'h001000);
    end
    gnt_pct = 100;
    for (int i = 0; i < 10 && rd_req; i++) cycle();
    wait_req(20, "s1_req2_seen");
    chk("s1_second_addr", rd_addr, 24'h001010);
    run_frames(2, 4000, "s1_frames");

    // long memory latency, random grants and return gaps
    lat = 40; gnt_pct = 60; mem_pct = 80; saw_max = 0;
    run_frames(3, 8000, "s3_frames");
    chk("s3_overlap", saw_max, 1);

    // FIFO back-pressure mid-frame
    lat = 10; gnt_pct = 100; mem_pct = 100;
    wait_idx(64, 2000, "s4_reach");
    idx0 = out_idx;
    disp_fifo_rdy = 1'b0;
    for (int i = 0; i < 200; i++) cycle();
    chk("s4_inflight_pushed", out_idx > idx0, 1);
    chk("s4_drained", outst, 0);
    disp_fifo_rdy = 1'b1;

    // enable dropped mid-frame: frame completes, then idle; restart at new base
    wait_idx(150, 2000, "s5_reach");
    enable = 1'b0;
    frame_base = 24'h080000;
    run_frames(4, 3000, "s5_finish");
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("s5_no_req", rd_req, 0);
    end
    chk("s5_idle", busy, 0);
    enable = 1'b1;
    wait_req(20, "s5_restart");
    chk("s5_new_base", rd_addr, 24'h080000);
    wait_idx(10, 500, "s5_mid");
    frame_base = 24'hFFFF80;
    gnt_pct = 80; mem_pct = 90;
    run_frames(5, 3000, "s5_frame5");
    wait_idx(100, 2000, "wrap_mid");
    enable = 1'b0;
    run_frames(6, 3000, "wrap_frame");
    wait_idle(50, "wrap_idle");

    // stray memory word with nothing outstanding
    inject_err = 1;
    cycle();
    cycle();
    chk("s6_perr_set", proto_err, 1);
    for (int i = 0; i < 5; i++) cycle();
    chk("s6_perr_sticky", proto_err, 1);

    // asynchronous reset mid-burst
    enable = 1'b1;
    frame_base = 24'h002000;
    wait_idx(20, 1000, "s6_mid");
    #2;
    rst_n = 1'b0;
    mem_rd_vld = 1'b0; rd_gnt = 1'b0; enable = 1'b0;
    #1;
    chk_zero_outputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    frame_base = 24'h003000;
    tgt = frames + 1;
    run_frames(tgt, 3000, "post_rst_frame");
    enable = 1'b0;
    wait_idle(50, "post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
